ioctl_ram_uploader: RTL and testbench

//  HPS-facing upload responder: serves ioctl read requests from core RAM (hiscore/NVRAM) back to HPS.

---
 rtl/ioctl_pkg.sv | 18 +
 rtl/upl_lat_pipe.sv | 31 +++
 rtl/ioctl_ram_uploader.sv | 197 +++++++++++++++++++
 tb/tb_ioctl_ram_uploader.sv | 333 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ioctl_pkg.sv
// Shared types and constants for the ioctl upload path.
package ioctl_pkg;

    localparam int IOCTL_ADDR_W = 25;
    localparam int IOCTL_DW     = 8;

    localparam logic [IOCTL_DW-1:0] FILL_BYTE = 8'hFF;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_GRANT = 3'd1,
        S_READY = 3'd2,
        S_READ  = 3'd3,
        S_LAT   = 3'd4,
        S_DONE  = 3'd5
    } upl_state_t;

endpackage

// File: rtl/upl_lat_pipe.sv
// RAM read latency tracker: a LAT-deep valid shift register whose last stage
// marks the cycle in which ram_q carries the data for an issued ram_rd.
module upl_lat_pipe #(
    parameter int LAT = 1
) (
    input  logic clk_sys,
    input  logic RESET_n,
    input  logic i_flush,
    input  logic i_strobe,
    output logic o_cap
);

    logic [LAT-1:0] r_v;

    // Shift the read strobe down the pipe; flush drops abandoned reads.
    always_ff @(posedge clk_sys or negedge RESET_n) begin
        if (!RESET_n) begin
            r_v <= '0;
        end else if (i_flush) begin
            r_v <= '0;
        end else begin
            r_v[0] <= i_strobe;
            for (int i = 1; i < LAT; i++) begin
                r_v[i] <= r_v[i-1];
            end
        end
    end

    assign o_cap = r_v[LAT-1];

endmodule

// File: rtl/ioctl_ram_uploader.sv
// HPS upload responder: answers ioctl reads for one index from a core RAM
// read port while holding the CPU paused for the whole session.
// Optional feature: UPLOAD_CSUM_EN makes address LENGTH return the two's
// complement of the 8-bit sum of RAM bytes served in the current session.
//
// state  | meaning
// IDLE   | no session; outputs quiet
// GRANT  | pause requested, waiting for paused
// READY  | accepting ioctl_rd
// READ   | ram_rd issued this cycle
// LAT    | waiting for RAM data capture strobe
// DONE   | session ended; drop pause_req
module ioctl_ram_uploader
    import ioctl_pkg::*;
#(
    parameter int ADDR_W  = 16,
    parameter int BASE    = 0,
    parameter int LENGTH  = 256,
    parameter int RAM_LAT = 1,
    parameter int INDEX   = 4
) (
    input  logic                    clk_sys,
    input  logic                    RESET_n,
    input  logic                    ioctl_upload,
    input  logic [7:0]              ioctl_index,
    input  logic                    ioctl_rd,
    input  logic [IOCTL_ADDR_W-1:0] ioctl_addr,
    output logic [IOCTL_DW-1:0]     ioctl_din,
    output logic                    ioctl_wait,
    output logic                    pause_req,
    input  logic                    paused,
    output logic [ADDR_W-1:0]       ram_addr,
    output logic                    ram_rd,
    input  logic [IOCTL_DW-1:0]     ram_q,
    output logic                    overrun
);

    upl_state_t r_state, w_state_nxt;

    logic                r_wait,   w_wait_nxt;
    logic                r_pause,  w_pause_nxt;
    logic [IOCTL_DW-1:0] r_din,    w_din_nxt;
    logic [ADDR_W-1:0]   r_ram_addr, w_addr_nxt;
    logic                r_ram_rd, w_ram_rd_nxt;
    logic                r_ovr,    w_ovr_nxt;

    logic                w_sess;
    logic                w_in_range;
    logic                w_is_csum;
    logic [IOCTL_DW-1:0] w_csum_byte;
    logic                w_cap;

    assign w_sess     = ioctl_upload && (ioctl_index == 8'(INDEX));
    assign w_in_range = ioctl_addr < IOCTL_ADDR_W'(LENGTH);

`ifdef UPLOAD_CSUM_EN
    logic [IOCTL_DW-1:0] r_sum;
    logic                w_sum_clr;
    logic                w_sum_add;

    assign w_is_csum   = ioctl_addr == IOCTL_ADDR_W'(LENGTH);
    assign w_csum_byte = ~r_sum + 8'd1;
    assign w_sum_clr   = (r_state == S_IDLE) && w_sess;
    assign w_sum_add   = (r_state == S_LAT) && w_sess && w_cap;

    // Running sum of RAM bytes returned since the session started.
    always_ff @(posedge clk_sys or negedge RESET_n) begin
        if (!RESET_n) begin
            r_sum <= '0;
        end else if (w_sum_clr) begin
            r_sum <= '0;
        end else if (w_sum_add) begin
            r_sum <= r_sum + ram_q;
        end
    end
`else
    assign w_is_csum   = 1'b0;
    assign w_csum_byte = FILL_BYTE;
`endif

    upl_lat_pipe #(
        .LAT      (RAM_LAT)
    ) u_lat_pipe (
        .clk_sys  (clk_sys),
        .RESET_n  (RESET_n),
        .i_flush  (r_state == S_DONE),
        .i_strobe (r_ram_rd),
        .o_cap    (w_cap)
    );

    // State and registered outputs.
    always_ff @(posedge clk_sys or negedge RESET_n) begin
        if (!RESET_n) begin
            r_state    <= S_IDLE;
            r_wait     <= 1'b0;
            r_pause    <= 1'b0;
            r_din      <= '0;
            r_ram_addr <= '0;
            r_ram_rd   <= 1'b0;
            r_ovr      <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_wait     <= w_wait_nxt;
            r_pause    <= w_pause_nxt;
            r_din      <= w_din_nxt;
            r_ram_addr <= w_addr_nxt;
            r_ram_rd   <= w_ram_rd_nxt;
            r_ovr      <= w_ovr_nxt;
        end
    end

    // Next-state and output decisions. Session end wins over everything so an
    // outstanding read is dropped without issuing ram_rd. In IDLE a high sess
    // is always a fresh rise, since every session end passes through DONE.
    always_comb begin
        w_state_nxt  = r_state;
        w_wait_nxt   = r_wait;
        w_pause_nxt  = r_pause;
        w_din_nxt    = r_din;
        w_addr_nxt   = r_ram_addr;
        w_ram_rd_nxt = 1'b0;
        w_ovr_nxt    = r_ovr | (ioctl_rd & r_wait);
        case (r_state)
            S_IDLE: begin
                if (w_sess) begin
                    w_state_nxt = S_GRANT;
                    w_pause_nxt = 1'b1;
                    w_wait_nxt  = 1'b1;
                    w_ovr_nxt   = 1'b0;
                end
            end
            S_GRANT: begin
                if (!w_sess) begin
                    w_state_nxt = S_DONE;
                    w_wait_nxt  = 1'b0;
                end else if (paused) begin
                    w_state_nxt = S_READY;
                    w_wait_nxt  = 1'b0;
                end
            end
            S_READY: begin
                if (!w_sess) begin
                    w_state_nxt = S_DONE;
                    w_wait_nxt  = 1'b0;
                end else if (r_wait) begin
                    // closes the one-cycle wait pulse of a non-RAM read
                    w_wait_nxt = 1'b0;
                end else if (ioctl_rd) begin
                    w_wait_nxt = 1'b1;
                    if (w_in_range) begin
                        w_addr_nxt   = ADDR_W'(BASE) + ioctl_addr[ADDR_W-1:0];
                        w_ram_rd_nxt = 1'b1;
                        w_state_nxt  = S_READ;
                    end else begin
                        w_din_nxt = w_is_csum ? w_csum_byte : FILL_BYTE;
                    end
                end
            end
            S_READ: begin
                if (!w_sess) begin
                    w_state_nxt = S_DONE;
                    w_wait_nxt  = 1'b0;
                end else begin
                    w_state_nxt = S_LAT;
                end
            end
            S_LAT: begin
                if (!w_sess) begin
                    w_state_nxt = S_DONE;
                    w_wait_nxt  = 1'b0;
                end else if (w_cap) begin
                    w_din_nxt   = ram_q;
                    w_wait_nxt  = 1'b0;
                    w_state_nxt = S_READY;
                end
            end
            S_DONE: begin
                w_pause_nxt = 1'b0;
                w_wait_nxt  = 1'b0;
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_pause_nxt = 1'b0;
                w_wait_nxt  = 1'b0;
            end
        endcase
    end

    assign ioctl_din  = r_din;
    assign ioctl_wait = r_wait;
    assign pause_req  = r_pause;
    assign ram_addr   = r_ram_addr;
    assign ram_rd     = r_ram_rd;
    assign overrun    = r_ovr;

endmodule

// File: tb/tb_ioctl_ram_uploader.sv
// Bench for ioctl_ram_uploader with BASE near the top of RAM (address wrap),
// LENGTH=64 and a two-cycle RAM. Builds with or without UPLOAD_CSUM_EN.
module tb_ioctl_ram_uploader;

    localparam int          LEN    = 64;
    localparam int          LAT    = 2;
    localparam logic [15:0] BASE_P = 16'hFFF0;

    logic        clk_sys = 1'b0;
    logic        RESET_n = 1'b0;
    logic        ioctl_upload = 1'b0;
    logic [7:0]  ioctl_index = 8'd0;
    logic        ioctl_rd = 1'b0;
    logic [24:0] ioctl_addr = '0;
    logic [7:0]  ioctl_din;
    logic        ioctl_wait;
    logic        pause_req;
    logic        paused = 1'b0;
    logic [15:0] ram_addr;
    logic        ram_rd;
    logic [7:0]  ram_q;
    logic        overrun;

    int n_tests = 0;
    int n_fail  = 0;
    logic [7:0] sum_model = 8'd0;

    ioctl_ram_uploader #(
        .ADDR_W       (16),
        .BASE         (int'(BASE_P)),
        .LENGTH       (LEN),
        .RAM_LAT      (LAT),
        .INDEX        (4)
    ) dut (
        .clk_sys      (clk_sys),
        .RESET_n      (RESET_n),
        .ioctl_upload (ioctl_upload),
        .ioctl_index  (ioctl_index),
        .ioctl_rd     (ioctl_rd),
        .ioctl_addr   (ioctl_addr),
        .ioctl_din    (ioctl_din),
        .ioctl_wait   (ioctl_wait),
        .pause_req    (pause_req),
        .paused       (paused),
        .ram_addr     (ram_addr),
        .ram_rd       (ram_rd),
        .ram_q        (ram_q),
        .overrun      (overrun)
    );

    always #5 clk_sys = ~clk_sys;

    // Behavioural RAM: data appears exactly LAT cycles after a ram_rd cycle,
    // junk (EE) otherwise, so a mistimed capture is visible.
    logic [7:0] mem [0:65535];
    logic [7:0] q1 = 8'h00, q2 = 8'h00;
    always @(posedge clk_sys) begin
        q1 <= ram_rd ? mem[ram_addr] : 8'hEE;
        q2 <= q1;
    end
    assign ram_q = q2;

    typedef struct {
        logic [24:0] addr;
        logic [7:0]  exp_din;
        int          exp_wait;
        int          exp_rd;
        logic [15:0] exp_ram_addr;
    } vec_t;

    vec_t vecs[7];

    function automatic logic [15:0] phys(input logic [24:0] a);
        return BASE_P + a[15:0];
    endfunction

    function automatic logic [7:0] model_byte(input logic [24:0] a, input logic [7:0] s);
        if (a < 25'(LEN)) return mem[phys(a)];
`ifdef UPLOAD_CSUM_EN
        if (a == 25'(LEN)) return ~s + 8'd1;
`endif
        return 8'hFF;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic do_read(input logic [24:0] a, output logic [7:0] din, output int n_wait,
                           output int n_rd, output logic [15:0] rd_addr);
        @(negedge clk_sys);
        ioctl_addr = a;
        ioctl_rd   = 1'b1;
        @(negedge clk_sys);
        ioctl_rd = 1'b0;
        n_wait  = 0;
        n_rd    = 0;
        rd_addr = '0;
        while (ioctl_wait === 1'b1 && n_wait < 16) begin
            if (ram_rd) begin
                n_rd++;
                rd_addr = ram_addr;
            end
            n_wait++;
            @(negedge clk_sys);
        end
        if (ram_rd) n_rd++;
        din = ioctl_din;
    endtask

    task automatic start_session(input int grant_delay);
        @(negedge clk_sys);
        ioctl_index  = 8'd4;
        ioctl_upload = 1'b1;
        @(negedge clk_sys);
        check("start_pause_req", pause_req, 1);
        check("start_wait_hi", ioctl_wait, 1);
        check("start_overrun_clr", overrun, 0);
        repeat (grant_delay - 1) @(negedge clk_sys);
        if (grant_delay > 1) check("grant_wait_hi", ioctl_wait, 1);
        paused = 1'b1;
        @(negedge clk_sys);
        check("grant_wait_lo", ioctl_wait, 0);
        sum_model = 8'd0;
    endtask

    task automatic end_session();
        @(negedge clk_sys);
        ioctl_upload = 1'b0;
        repeat (2) @(negedge clk_sys);
        check("end_pause_req", pause_req, 0);
        paused = 1'b0;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0]  din, last;
        logic [15:0] ra;
        logic [7:0]  s;
        logic [24:0] a;
        int          nw, nr;

        for (int i = 0; i < 65536; i++) mem[i] = 8'($urandom);
        mem[16'hFFF3] = 8'h5A;

        // reset state
        repeat (3) @(negedge clk_sys);
        check("reset_outputs", {ioctl_din, ioctl_wait, pause_req, ram_addr, ram_rd, overrun}, 0);
        RESET_n = 1'b1;
        repeat (2) @(negedge clk_sys);
        check("idle_no_pause", pause_req, 0);

        // session start with grant after 5 cycles
        start_session(5);

        // table: in-range, wrap, boundaries, out of range
        vecs[0] = '{25'd3,        8'h00, 3, 1, 16'hFFF3};
        vecs[1] = '{25'd0,        8'h00, 3, 1, 16'hFFF0};
        vecs[2] = '{25'd63,       8'h00, 3, 1, 16'h002F};
        vecs[3] = '{25'd32,       8'h00, 3, 1, 16'h0010};
        vecs[4] = '{25'd64,       8'h00, 1, 0, 16'h0000};
        vecs[5] = '{25'd71,       8'h00, 1, 0, 16'h0000};
        vecs[6] = '{25'h1FFFFFF,  8'h00, 1, 0, 16'h0000};
        s = 8'd0;
        for (int i = 0; i < 7; i++) begin
            vecs[i].exp_din = model_byte(vecs[i].addr, s);
            if (vecs[i].addr < 25'(LEN)) s = s + vecs[i].exp_din;
        end
        check("vec_5a_value", vecs[0].exp_din, 8'h5A);

        for (int i = 0; i < 7; i++) begin
            do_read(vecs[i].addr, din, nw, nr, ra);
            check($sformatf("vec%0d_din", i), din, vecs[i].exp_din);
            check($sformatf("vec%0d_wait_cycles", i), nw, vecs[i].exp_wait);
            check($sformatf("vec%0d_ram_rd_count", i), nr, vecs[i].exp_rd);
            if (vecs[i].exp_rd == 1) check($sformatf("vec%0d_ram_addr", i), ra, vecs[i].exp_ram_addr);
            if (vecs[i].addr < 25'(LEN)) sum_model = sum_model + vecs[i].exp_din;
        end
        last = ioctl_din;
        repeat (3) @(negedge clk_sys);
        check("din_holds", ioctl_din, last);
        check("no_overrun_yet", overrun, 0);

        // paused drops mid-session: data still returned, pause_req held
        paused = 1'b0;
        do_read(25'd5, din, nw, nr, ra);
        check("unpaused_din", din, mem[phys(25'd5)]);
        check("unpaused_pause_req", pause_req, 1);
        sum_model = sum_model + mem[phys(25'd5)];
        paused = 1'b1;

        // second strobe during an outstanding read
        @(negedge clk_sys);
        ioctl_addr = 25'd7;
        ioctl_rd   = 1'b1;
        @(negedge clk_sys);
        nr = int'(ram_rd);
        ioctl_addr = 25'd9;
        @(negedge clk_sys);
        ioctl_rd = 1'b0;
        check("overrun_set", overrun, 1);
        nw = 0;
        while (ioctl_wait === 1'b1 && nw < 16) begin
            nr += int'(ram_rd);
            nw++;
            @(negedge clk_sys);
        end
        check("overrun_no_timeout", nw < 16, 1);
        check("overrun_ram_rd_count", nr, 1);
        check("overrun_first_data", ioctl_din, mem[phys(25'd7)]);
        check("overrun_sticky", overrun, 1);
        end_session();
        start_session(2);

        // randomized reads against the model
        for (int i = 0; i < 40; i++) begin
            logic [7:0] e;
            a = 25'($urandom_range(0, LEN + 8));
            e = model_byte(a, sum_model);
            do_read(a, din, nw, nr, ra);
            check($sformatf("rand%0d_din", i), din, e);
            check($sformatf("rand%0d_wait", i), nw, (a < 25'(LEN)) ? LAT + 1 : 1);
            if (a < 25'(LEN)) begin
                check($sformatf("rand%0d_ram_addr", i), ra, phys(a));
                sum_model = sum_model + e;
            end else begin
                check($sformatf("rand%0d_no_ram_rd", i), nr, 0);
            end
        end
        end_session();

        // checksum byte after 01,02,03
        mem[phys(25'd0)] = 8'h01;
        mem[phys(25'd1)] = 8'h02;
        mem[phys(25'd2)] = 8'h03;
        start_session(1);
        for (int i = 0; i < 3; i++) begin
            do_read(25'(i), din, nw, nr, ra);
            check($sformatf("csum_byte%0d", i), din, 8'(i + 1));
        end
        do_read(25'(LEN), din, nw, nr, ra);
`ifdef UPLOAD_CSUM_EN
        check("csum_value", din, 8'hFA);
`else
        check("csum_absent_fill", din, 8'hFF);
`endif
        check("csum_no_ram_rd", nr, 0);
        do_read(25'(LEN), din, nw, nr, ra);
`ifdef UPLOAD_CSUM_EN
        check("csum_repeat", din, 8'hFA);
`else
        check("csum_repeat_fill", din, 8'hFF);
`endif
        do_read(25'(LEN + 1), din, nw, nr, ra);
        check("past_csum_fill", din, 8'hFF);

        // upload drops while waiting on RAM latency
        last = ioctl_din;
        @(negedge clk_sys);
        ioctl_addr = 25'd10;
        ioctl_rd   = 1'b1;
        @(negedge clk_sys);
        ioctl_rd = 1'b0;
        @(negedge clk_sys);
        ioctl_upload = 1'b0;
        @(negedge clk_sys);
        check("drop_wait_lo", ioctl_wait, 0);
        check("drop_pause_still", pause_req, 1);
        check("drop_no_ram_rd", ram_rd, 0);
        @(negedge clk_sys);
        check("drop_pause_lo", pause_req, 0);
        repeat (3) @(negedge clk_sys);
        check("drop_din_kept", ioctl_din, last);
        paused = 1'b0;

        // wrong index is ignored
        ioctl_index  = 8'd3;
        ioctl_upload = 1'b1;
        repeat (4) @(negedge clk_sys);
        check("idx3_pause", pause_req, 0);
        check("idx3_wait", ioctl_wait, 0);
        ioctl_upload = 1'b0;
        ioctl_index  = 8'd4;

        // one-cycle session
        @(negedge clk_sys);
        ioctl_upload = 1'b1;
        @(negedge clk_sys);
        ioctl_upload = 1'b0;
        check("short_pause_hi", pause_req, 1);
        check("short_wait_hi", ioctl_wait, 1);
        @(negedge clk_sys);
        check("short_pause_still", pause_req, 1);
        check("short_wait_lo", ioctl_wait, 0);
        @(negedge clk_sys);
        check("short_pause_lo", pause_req, 0);

        // async reset in the middle of a read
        start_session(1);
        @(negedge clk_sys);
        ioctl_addr = 25'd3;
        ioctl_rd   = 1'b1;
        @(negedge clk_sys);
        ioctl_rd = 1'b0;
        check("rst_read_issued", ram_rd, 1);
        #2 RESET_n = 1'b0;
        #1 check("rst_async_outputs", {ioctl_din, ioctl_wait, pause_req, ram_addr, ram_rd, overrun}, 0);
        @(negedge clk_sys);
        check("rst_no_ram_rd", ram_rd, 0);
        ioctl_upload = 1'b0;
        paused       = 1'b0;
        RESET_n      = 1'b1;
        @(negedge clk_sys);
        start_session(2);
        do_read(25'd3, din, nw, nr, ra);
        check("post_rst_din", din, 8'h5A);
        check("post_rst_wait", nw, LAT + 1);
        end_session();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
